// File: rtl/otter_mem_pkg.sv
// otter_mem_pkg: shared access-size and responder-state types plus alignment helper
package otter_mem_pkg;
  typedef enum logic [1:0] {SZ_BYTE = 2'd0, SZ_HALF = 2'd1, SZ_WORD = 2'd2} mem_size_t;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;
  function automatic logic is_misaligned(input logic [1:0] addr, input logic [1:0] size);
    return (size == SZ_HALF && addr[0]) || (size == SZ_WORD && addr != 2'b00);
  endfunction
endpackage

// File: rtl/otter_load_align.sv
// otter_load_align: load lane select/extension and store lane replication/byte enables
module otter_load_align
  import otter_mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [31:0] wlanes,
  output logic [3:0]  be
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    rdata = size == SZ_BYTE ? {{24{~uns & b[7]}}, b} :
            size == SZ_HALF ? {{16{~uns & h[15]}}, h} : word;
    wlanes = size == SZ_BYTE ? {4{wdata[7:0]}} : size == SZ_HALF ? {2{wdata[15:0]}} : wdata;
    be = size == SZ_BYTE ? 4'b0001 << off :
         size == SZ_HALF ? (off[1] ? 4'b1100 : 4'b0011) :
         size == SZ_WORD ? 4'b1111 : 4'b0000;
  end
endmodule

// File: rtl/otter_dmem_responder.sv
// otter_dmem_responder: fixed-latency data RAM responder with stall and error reporting
module otter_dmem_responder
  import otter_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 16384,
  parameter int LATENCY     = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic        req_re,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        stall
);
  localparam int IW = $clog2(DEPTH_WORDS);
  localparam logic [29:0] DEPTH_LIM = 30'(DEPTH_WORDS);
  localparam logic [3:0] WAIT_CNT = LATENCY > 1 ? 4'(LATENCY - 2) : 4'd0;
  localparam logic ONE_CYCLE = LATENCY == 1;
  dmem_state_t state;
  logic [3:0] cnt;
  logic [31:0] l_addr, l_wdata, a_addr, a_wdata, word, wlanes, rdata_ext;
  logic [1:0] l_size, a_size;
  logic [3:0] be;
  logic [IW-1:0] idx;
  logic l_uns, l_we, a_uns, a_we, idle, accept, err, enter_resp;
  logic [31:0] mem [DEPTH_WORDS];
  // In IDLE the live request drives the access so a one-cycle latency needs no extra register stage
  assign idle       = state == IDLE;
  assign accept     = idle & req_valid & (req_re | req_we);
  assign a_addr     = idle ? req_addr : l_addr;
  assign a_size     = idle ? req_size : l_size;
  assign a_uns      = idle ? req_unsigned : l_uns;
  assign a_wdata    = idle ? req_wdata : l_wdata;
  assign a_we       = idle ? req_we : l_we;
  assign err        = a_size == 2'd3 || is_misaligned(a_addr[1:0], a_size) || a_addr[31:2] >= DEPTH_LIM;
  assign enter_resp = (accept & (err | ONE_CYCLE)) | (state == WAIT && cnt == 4'd0);
  assign idx        = a_addr[IW+1:2];
  assign word       = mem[idx];
  assign req_ready  = idle;
  assign stall      = accept | state == WAIT;
  otter_load_align u_align (
    .word  (word),
    .off   (a_addr[1:0]),
    .size  (a_size),
    .uns   (a_uns),
    .wdata (a_wdata),
    .rdata (rdata_ext),
    .wlanes(wlanes),
    .be    (be)
  );
  always_ff @(posedge CLK)
    if (!RST && enter_resp && a_we && !err)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wlanes[8*i +: 8];
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= enter_resp;
      if (enter_resp) begin
        rsp_err   <= err;
        rsp_rdata <= (err | a_we) ? 32'd0 : rdata_ext;
      end
      case (state)
        IDLE: if (accept) begin
          l_addr  <= req_addr;
          l_size  <= req_size;
          l_uns   <= req_unsigned;
          l_wdata <= req_wdata;
          l_we    <= req_we;
          cnt     <= WAIT_CNT;
          state   <= enter_resp ? RESP : WAIT;
        end
        WAIT: if (cnt == 4'd0) state <= RESP; else cnt <= cnt - 4'd1;
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
